// File: rtl/logic_unit_arbiter.sv
// Round-robin arbiter and sequencer in front of one shared 32-bit logic unit
// (AND/OR/XOR/NOR plus zero flag). One operation in flight at a time:
// IDLE grants and latches a request, EXEC computes and registers the result,
// RESP presents it until the consumer takes it.
module logic_unit_arbiter #(
  parameter int WIDTH = 32,
  parameter int NREQ  = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NREQ-1:0]       req_valid,
  output logic [NREQ-1:0]       req_ready,
  input  logic [NREQ*WIDTH-1:0] req_inA,
  input  logic [NREQ*WIDTH-1:0] req_inB,
  input  logic [NREQ*2-1:0]     req_op,
  output logic                  res_valid,
  input  logic                  res_ready,
  output logic [WIDTH-1:0]      res_out,
  output logic                  res_flag,
  output logic [1:0]            res_id,
  output logic                  busy
);

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_EXEC = 2'b01,
    S_RESP = 2'b10
  } state_t;

  state_t           r_state;
  state_t           w_next;
  logic [1:0]       r_ptr;
  logic [1:0]       r_id;
  logic [1:0]       r_op;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [1:0]       w_gidx;
  logic [1:0]       w_cand;
  logic             w_found;
  logic             w_accept;
  logic [WIDTH-1:0] w_result;

  // Round-robin scan: first valid requester at or after r_ptr (mod NREQ)
  always_comb begin
    w_found = 1'b0;
    w_gidx  = '0;
    w_cand  = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      w_cand = r_ptr + 2'(i);
      if (!w_found && req_valid[w_cand]) begin
        w_found = 1'b1;
        w_gidx  = w_cand;
      end
    end
  end

  assign w_accept = (r_state == S_IDLE) && w_found && !rst;

  // One-hot grant, only offered while idle and out of reset
  always_comb begin
    req_ready = '0;
    if (w_accept) begin
      req_ready[w_gidx] = 1'b1;
    end
  end

  // Shared logic unit operating on the latched operands
  always_comb begin
    w_result = '0;
    case (r_op)
      2'b00:   w_result = r_a & r_b;
      2'b01:   w_result = r_a | r_b;
      2'b10:   w_result = r_a ^ r_b;
      default: w_result = ~(r_a | r_b);
    endcase
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state logic; the spare encoding falls back to IDLE
  always_comb begin
    w_next = S_IDLE;
    case (r_state)
      S_IDLE:  w_next = w_accept ? S_EXEC : S_IDLE;
      S_EXEC:  w_next = S_RESP;
      S_RESP:  w_next = res_ready ? S_IDLE : S_RESP;
      default: w_next = S_IDLE;
    endcase
  end

  // Request capture on grant, result registration in EXEC; reset aborts both
  always_ff @(posedge clk) begin
    if (rst) begin
      r_ptr    <= '0;
      r_id     <= '0;
      r_op     <= '0;
      r_a      <= '0;
      r_b      <= '0;
      res_out  <= '0;
      res_flag <= 1'b0;
      res_id   <= '0;
    end else begin
      if (w_accept) begin
        r_a   <= req_inA[int'(w_gidx)*WIDTH +: WIDTH];
        r_b   <= req_inB[int'(w_gidx)*WIDTH +: WIDTH];
        r_op  <= req_op[int'(w_gidx)*2 +: 2];
        r_id  <= w_gidx;
        r_ptr <= w_gidx + 2'd1;
      end
      if (r_state == S_EXEC) begin
        res_out  <= w_result;
        res_flag <= (w_result == '0);
        res_id   <= r_id;
      end
    end
  end

  assign res_valid = (r_state == S_RESP);
  assign busy      = (r_state != S_IDLE);

endmodule

// File: tb/tb_logic_unit_arbiter.sv
// Self-checking bench for logic_unit_arbiter: vector table for single
// operations, directed sequences for round-robin order, backpressure,
// pointer wrap and reset during an operation. Results go through a queue.
module tb_logic_unit_arbiter;

  logic         clk = 1'b0;
  logic         rst;
  logic [3:0]   req_valid;
  logic [3:0]   req_ready;
  logic [127:0] req_inA;
  logic [127:0] req_inB;
  logic [7:0]   req_op;
  logic         res_valid;
  logic         res_ready;
  logic [31:0]  res_out;
  logic         res_flag;
  logic [1:0]   res_id;
  logic         busy;

  logic [31:0] tA [4];
  logic [31:0] tB [4];
  logic [1:0]  tOp[4];

  assign req_inA = {tA[3], tA[2], tA[1], tA[0]};
  assign req_inB = {tB[3], tB[2], tB[1], tB[0]};
  assign req_op  = {tOp[3], tOp[2], tOp[1], tOp[0]};

  logic_unit_arbiter #(.WIDTH(32), .NREQ(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_inA   (req_inA),
    .req_inB   (req_inB),
    .req_op    (req_op),
    .res_valid (res_valid),
    .res_ready (res_ready),
    .res_out   (res_out),
    .res_flag  (res_flag),
    .res_id    (res_id),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] out;
    logic        flag;
    logic [1:0]  id;
  } exp_t;

  typedef struct {
    int          id;
    logic [31:0] a;
    logic [31:0] b;
    logic [1:0]  op;
    logic [31:0] exp_out;
    logic        exp_flag;
  } vec_t;

  exp_t sbq[$];
  vec_t vt[6];
  int   checks = 0;
  int   errors = 0;

  function automatic logic [31:0] model(input logic [1:0] op,
                                        input logic [31:0] a,
                                        input logic [31:0] b);
    case (op)
      2'b00:   return a & b;
      2'b01:   return a | b;
      2'b10:   return a ^ b;
      default: return ~(a | b);
    endcase
  endfunction

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic push_exp(input logic [31:0] o, input logic f, input int g);
    exp_t e;
    e.out  = o;
    e.flag = f;
    e.id   = 2'(g);
    sbq.push_back(e);
  endtask

  // Called at a negedge where a result handshake is expected
  task automatic pop_check();
    exp_t e;
    if (sbq.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL sb_pop actual=result id %0d out %h required=no result",
               res_id, res_out);
    end else begin
      e = sbq.pop_front();
      chk("res_valid_hs", 32'(res_valid), 32'd1);
      chk("res_out", res_out, e.out);
      chk("res_flag", 32'(res_flag), 32'(e.flag));
      chk("res_id", 32'(res_id), 32'(e.id));
    end
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    rst       = 1'b1;
    req_valid = '0;
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  // Full transaction with res_ready high: grant, EXEC, RESP, back to IDLE
  task automatic issue(input logic [3:0] mask, input int g,
                       input logic [31:0] eo, input logic ef);
    @(posedge clk); #1;
    req_valid = mask;
    @(negedge clk);
    chk("grant", 32'(req_ready), 32'(1 << g));
    chk("idle_busy", 32'(busy), 32'd0);
    push_exp(eo, ef, g);
    @(posedge clk); #1;
    req_valid = '0;
    @(negedge clk);
    chk("exec_res_valid", 32'(res_valid), 32'd0);
    chk("exec_busy", 32'(busy), 32'd1);
    @(negedge clk);
    pop_check();
    @(negedge clk);
    chk("back_idle", 32'(busy), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1);
  end

  initial begin
    vt[0] = '{0, 32'h0000_00F0, 32'h0000_000F, 2'b01, 32'h0000_00FF, 1'b0};
    vt[1] = '{2, 32'hAAAA_AAAA, 32'h5555_5555, 2'b00, 32'h0000_0000, 1'b1};
    vt[2] = '{1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 2'b11, 32'h0000_0000, 1'b1};
    vt[3] = '{3, 32'h1234_5678, 32'hFFFF_FFFF, 2'b10, 32'hEDCB_A987, 1'b0};
    vt[4] = '{1, 32'h0000_0000, 32'h0000_0000, 2'b11, 32'hFFFF_FFFF, 1'b0};
    vt[5] = '{0, 32'h0F0F_0F0F, 32'h00FF_00FF, 2'b10, 32'h0FF0_0FF0, 1'b0};

    for (int i = 0; i < 4; i++) begin
      tA[i]  = '0;
      tB[i]  = '0;
      tOp[i] = '0;
    end
    rst       = 1'b1;
    res_ready = 1'b1;
    req_valid = 4'hF;

    // Reset state, with all requests asserted during reset
    @(negedge clk);
    @(negedge clk);
    chk("rst_req_ready", 32'(req_ready), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_res_valid", 32'(res_valid), 32'd0);
    chk("rst_res_out", res_out, 32'd0);
    chk("rst_res_flag", 32'(res_flag), 32'd0);
    chk("rst_res_id", 32'(res_id), 32'd0);
    @(posedge clk); #1;
    rst       = 1'b0;
    req_valid = '0;

    // Vector table: one requester at a time
    for (int i = 0; i < 6; i++) begin
      tA[vt[i].id]  = vt[i].a;
      tB[vt[i].id]  = vt[i].b;
      tOp[vt[i].id] = vt[i].op;
      issue(4'(1 << vt[i].id), vt[i].id, vt[i].exp_out, vt[i].exp_flag);
    end

    // Round robin with all four valid: grants 0,1,2,3,0 every 3 cycles
    do_reset();
    for (int i = 0; i < 4; i++) begin
      tA[i]  = 32'h1111_1111 * (i + 1);
      tB[i]  = ~(32'h0F0F_0000 >> i);
      tOp[i] = 2'(i);
    end
    @(posedge clk); #1;
    req_valid = 4'hF;
    for (int k = 0; k < 5; k++) begin
      int g;
      g = k % 4;
      @(negedge clk);
      chk("rr_grant", 32'(req_ready), 32'(1 << g));
      push_exp(model(tOp[g], tA[g], tB[g]),
               model(tOp[g], tA[g], tB[g]) == 32'd0, g);
      @(negedge clk);
      chk("rr_exec_ready", 32'(req_ready), 32'd0);
      chk("rr_exec_valid", 32'(res_valid), 32'd0);
      @(negedge clk);
      chk("rr_resp_ready", 32'(req_ready), 32'd0);
      pop_check();
    end
    @(posedge clk); #1;
    req_valid = '0;

    // Backpressure on XOR, plus a request arriving during the busy period
    tA[3]  = 32'h1234_5678;
    tB[3]  = 32'hFFFF_FFFF;
    tOp[3] = 2'b10;
    @(posedge clk); #1;
    req_valid = 4'b1000;
    res_ready = 1'b0;
    @(negedge clk);
    chk("bp_grant", 32'(req_ready), 32'b1000);
    push_exp(32'hEDCB_A987, 1'b0, 3);
    @(posedge clk); #1;
    tA[0]     = 32'hC0FF_EE00;
    tB[0]     = 32'h0000_00FF;
    tOp[0]    = 2'b01;
    req_valid = 4'b0001;
    @(negedge clk);
    chk("bp_exec_ready", 32'(req_ready), 32'd0);
    chk("bp_exec_valid", 32'(res_valid), 32'd0);
    repeat (5) begin
      @(negedge clk);
      chk("bp_valid", 32'(res_valid), 32'd1);
      chk("bp_out_stable", res_out, 32'hEDCB_A987);
      chk("bp_busy", 32'(busy), 32'd1);
      chk("bp_ready_held", 32'(req_ready), 32'd0);
    end
    @(posedge clk); #1;
    res_ready = 1'b1;
    @(negedge clk);
    chk("hs_cycle_ready", 32'(req_ready), 32'd0);
    pop_check();
    @(negedge clk);
    chk("after_hs_grant", 32'(req_ready), 32'b0001);
    chk("after_hs_valid", 32'(res_valid), 32'd0);
    chk("after_hs_busy", 32'(busy), 32'd0);
    chk("after_hs_retain", res_out, 32'hEDCB_A987);
    push_exp(32'hC0FF_EEFF, 1'b0, 0);
    @(posedge clk); #1;
    req_valid = '0;
    @(negedge clk);
    @(negedge clk);
    pop_check();
    @(negedge clk);
    chk("after_hs_idle", 32'(busy), 32'd0);

    // Skip and wrap: ptr 3 with only requester 2, then 3 before 0
    do_reset();
    issue(4'b0100, 2, model(tOp[2], tA[2], tB[2]), model(tOp[2], tA[2], tB[2]) == 0);
    issue(4'b0100, 2, model(tOp[2], tA[2], tB[2]), model(tOp[2], tA[2], tB[2]) == 0);
    issue(4'b1001, 3, model(tOp[3], tA[3], tB[3]), model(tOp[3], tA[3], tB[3]) == 0);
    issue(4'b1111, 0, model(tOp[0], tA[0], tB[0]), model(tOp[0], tA[0], tB[0]) == 0);

    // Reset in EXEC: transaction dropped, pointer and outputs cleared
    @(posedge clk); #1;
    req_valid = 4'b0010;
    @(negedge clk);
    chk("mid_grant", 32'(req_ready), 32'b0010);
    @(posedge clk); #1;
    req_valid = '0;
    rst       = 1'b1;
    @(negedge clk);
    chk("mid_exec_busy", 32'(busy), 32'd1);
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (3) begin
      @(negedge clk);
      chk("mid_no_valid", 32'(res_valid), 32'd0);
      chk("mid_busy", 32'(busy), 32'd0);
      chk("mid_res_out", res_out, 32'd0);
      chk("mid_res_flag", 32'(res_flag), 32'd0);
      chk("mid_res_id", 32'(res_id), 32'd0);
    end
    issue(4'b1111, 0, model(tOp[0], tA[0], tB[0]), model(tOp[0], tA[0], tB[0]) == 0);

    chk("sb_empty", 32'(sbq.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/logic_unit_arbiter.md
# logic_unit_arbiter

Round-robin arbiter and sequencer sharing one 32-bit bitwise logic unit (AND/OR/XOR/NOR with zero flag) among four requesters. It accepts one operation at a time through a valid/ready handshake, executes it in a dedicated cycle and returns a registered result tagged with the requester ID. It sits between the ALU front-end issue ports and the shared logic datapath, replacing per-port copies of the OR/logic unit.

## Interface
- WIDTH, 32: operand/result width.
- NREQ, 4: number of requesters. Fixed at 4; the ID is 2 bits.
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous, active-high reset.
- req_valid  in  NREQ  per-requester request valid.
- req_ready  out  NREQ  one-hot grant. Combinational. Non-zero only in IDLE.
- req_inA  in  NREQ*WIDTH  operand A. Requester i occupies bits [i*WIDTH +: WIDTH].
- req_inB  in  NREQ*WIDTH  operand B, same packing as req_inA.
- req_op  in  NREQ*2  opcode, packed [i*2 +: 2]: 00 AND, 01 OR, 10 XOR, 11 NOR.
- res_valid  out  1  result valid.
- res_ready  in  1  result consumer ready.
- res_out  out  WIDTH  registered result.
- res_flag  out  1  zero flag: 1 iff res_out == 0.
- res_id  out  2  index of the requester that owns the result.
- busy  out  1  1 whenever state != IDLE.

## Operation
- **States:** IDLE, EXEC, RESP. State is encoded in 2 bits. Unused encodings return to IDLE.
- **IDLE:**
  - Arbitration scans req_valid starting at ptr, then ptr+1, ptr+2, ptr+3, all mod 4.
  - The first set bit, g, wins and req_ready = 1<<g.
  - If no request is valid, req_ready = 0 and the block stays in IDLE.
- **Acceptance:** a request is accepted when req_valid[g] & req_ready[g]. On acceptance:
  - latch req_inA[g], req_inB[g], req_op[g] and g into internal registers;
  - ptr <= (g+1) mod 4, wrapping 3 -> 0;
  - next state is EXEC.
- **EXEC:**
  - Compute op(latched A, latched B).
  - Register res_out, res_flag = (result == 0) and res_id = g.
  - Next state is RESP.
- **RESP:**
  - res_valid = 1. res_out, res_flag and res_id are held stable.
  - On res_valid & res_ready, the next state is IDLE and res_valid drops the following cycle.
  - res_out, res_flag and res_id retain their values after the handshake until the next EXEC.
- **Requesters outside IDLE:** their req_valid is ignored and req_ready = 0. A requester holds valid and its data until it sees its ready bit.
- **ptr:** changes only on acceptance. A requester that drops valid before being granted loses nothing and is simply skipped.
- **NOR:** NOR of all-ones operands yields 0, so flag = 1. AND of disjoint operands also yields flag = 1.

## Timing
- **Reset values:** state IDLE, ptr 0, res_valid 0, res_out 0, res_flag 0, res_id 0, busy 0. req_ready is 0 during the reset cycle.
- **Latency:** acceptance in cycle T, EXEC in T+1, res_valid = 1 from T+2.
- **Throughput:** with res_ready held at 1, one operation per 3 cycles. The next acceptance is in cycle T+3.
- **Backpressure:** res_ready = 0 holds the block in RESP indefinitely with outputs stable and busy = 1.
- **Simultaneous events:**
  - All four requests valid with ptr = 2: grant order is 2, 3, 0, 1.
  - A new request arriving in the same cycle as a RESP handshake is not granted until the next cycle, when the block is back in IDLE.
- **Reset mid-operation:** rst in EXEC or RESP aborts the transaction.
  - No res_valid is produced for it.
  - The next cycle is IDLE with ptr = 0.

## Test plan
- **Single OR:** reset, then req_valid=0001 with A=0x0000_00F0, B=0x0000_000F, op=01.
  - req_ready=0001 in the same cycle.
  - res_valid two cycles later with res_out=0x0000_00FF, res_flag=0, res_id=0.
- **Zero flag:**
  - Requester 2, AND with A=0xAAAA_AAAA, B=0x5555_5555: res_out=0, res_flag=1, res_id=2.
  - NOR with A=B=0xFFFF_FFFF: res_out=0, res_flag=1.
- **Round-robin fairness:** req_valid=1111 held with res_ready=1.
  - Grants follow the order 0, 1, 2, 3, 0.
  - Acceptances occur every 3 cycles. res_id sequence is 0, 1, 2, 3, 0.
- **Backpressure:** res_ready=0 for 5 cycles after XOR A=0x1234_5678, B=0xFFFF_FFFF.
  - res_valid stays 1 with res_out=0xEDCB_A987 stable and busy=1.
  - When res_ready rises, the block returns to IDLE.
- **Skip and wrap:** ptr=3 and req_valid=0100.
  - Grant goes to 2, then ptr=3.
  - With req_valid=1001 next, the grant goes to 3, then ptr=0.
- **Reset mid-op:** assert rst in the EXEC cycle.
  - No res_valid appears.
  - Outputs and ptr return to reset values.
  - A subsequent request from requester 0 is granted first.
